// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: register read/write sequencer in front of i2c_master.
// Splits one register access into byte commands on the master's cmd/ws/dat
// port, watches stat_out for completion, and returns read data + error code.
module i2c_reg_seq #(
  parameter int TMO_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [2:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic [4:0] m_cmd,
  output logic       m_ws,
  output logic [7:0] m_dat,
  input  logic [6:0] m_stat,
  input  logic [7:0] m_dat_in
);

  // master command bits {NACK,WRTE,READ,STOP,STRT}; all-zero clears status
  localparam logic [4:0] C_CLRS = 5'h00;
  localparam logic [4:0] C_STRT = 5'h01;
  localparam logic [4:0] C_STOP = 5'h02;
  localparam logic [4:0] C_READ = 5'h04;
  localparam logic [4:0] C_WRTE = 5'h08;
  localparam logic [4:0] C_NACK = 5'h10;

  // master status bit positions {BBY,BSY,ACK,BBL,ALO,ERR,DON}
  localparam int S_DON = 0;
  localparam int S_ERR = 1;
  localparam int S_ALO = 2;
  localparam int S_BBL = 3;
  localparam int S_ACK = 4;
  localparam int S_BSY = 5;

  localparam logic [2:0] E_OK   = 3'd0;
  localparam logic [2:0] E_ANAK = 3'd1;
  localparam logic [2:0] E_DNAK = 3'd2;
  localparam logic [2:0] E_ARB  = 3'd3;
  localparam logic [2:0] E_BUSY = 3'd4;
  localparam logic [2:0] E_PROT = 3'd5;
  localparam logic [2:0] E_TMO  = 3'd6;

  localparam int            TW      = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TMO_CYC);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_LAT, ST_WAIT, ST_EVAL, ST_ABORT, ST_CLR, ST_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    phase;
  logic          rnw_q;
  logic [6:0]    addr_q;
  logic [7:0]    reg_q, wdata_q, rdata_q;
  logic [2:0]    err_q, err_nxt;
  logic          abort_q;
  logic [TW-1:0] tmo_cnt;

  logic done, tmo_hit, last_phase, wr_phase;
  logic [2:0] nack_code;
  logic unused_bby;

  // bus-busy bit is not needed: busy-bus conditions come back as ERR|BBL
  assign unused_bby = m_stat[6];

  assign done       = !m_stat[S_BSY] && m_stat[S_DON];
  assign tmo_hit    = (TMO_CYC != 0) && (tmo_cnt == TMO_LIM);
  assign last_phase = rnw_q ? (phase == 2'd3) : (phase == 2'd2);
  // the read-data byte (P3) is the only phase that does not check ACK
  assign wr_phase   = !(rnw_q && phase == 2'd3);
  // address bytes are P0 and the restart of a read; everything else is reg/data
  assign nack_code  = (phase == 2'd0 || (rnw_q && phase == 2'd2)) ? E_ANAK : E_DNAK;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state, error code selection and the write strobe
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    m_ws      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_ISSUE;
          err_nxt   = E_OK;
        end
      end
      ST_ISSUE: begin
        if (!m_stat[S_BSY]) begin
          m_ws      = 1'b1;
          state_nxt = ST_LAT;
        end
      end
      ST_LAT: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          state_nxt = abort_q ? ST_CLR : ST_EVAL;
        end else if (tmo_hit) begin
          // the master is left as-is; the caller must recover the bus
          err_nxt   = E_TMO;
          state_nxt = ST_RESP;
        end
      end
      ST_EVAL: begin
        if (m_stat[S_ERR]) begin
          if (m_stat[S_ALO])      err_nxt = E_ARB;
          else if (m_stat[S_BBL]) err_nxt = E_BUSY;
          else                    err_nxt = E_PROT;
          state_nxt = ST_CLR;
        end else if (wr_phase && !m_stat[S_ACK]) begin
          err_nxt   = nack_code;
          state_nxt = ST_ABORT;
        end else if (last_phase) begin
          err_nxt   = E_OK;
          state_nxt = ST_CLR;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ABORT: state_nxt = ST_ISSUE;
      ST_CLR: begin
        if (!m_stat[S_BSY]) begin
          m_ws      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // request latch, phase/command sequencing, timeout counter, response regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 2'd0;
      rnw_q     <= 1'b0;
      addr_q    <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      err_q     <= E_OK;
      abort_q   <= 1'b0;
      tmo_cnt   <= '0;
      m_cmd     <= C_CLRS;
      m_dat     <= 8'd0;
      rsp_err   <= E_OK;
      rsp_rdata <= 8'd0;
    end else begin
      err_q <= err_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rnw_q   <= req_rnw;
            addr_q  <= req_addr;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            phase   <= 2'd0;
            abort_q <= 1'b0;
            m_cmd   <= C_STRT | C_WRTE;
            m_dat   <= {req_addr, 1'b0};
          end
        end
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          if (tmo_cnt != {TW{1'b1}}) tmo_cnt <= tmo_cnt + 1'b1;
        end
        ST_EVAL: begin
          if (phase == 2'd3) rdata_q <= m_dat_in;
          if (state_nxt == ST_ISSUE) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: begin
                m_cmd <= C_WRTE;
                m_dat <= reg_q;
              end
              2'd1: begin
                if (rnw_q) begin
                  m_cmd <= C_STRT | C_WRTE;
                  m_dat <= {addr_q, 1'b1};
                end else begin
                  m_cmd <= C_WRTE | C_STOP;
                  m_dat <= wdata_q;
                end
              end
              default: begin
                m_cmd <= C_READ | C_NACK | C_STOP;
                m_dat <= 8'hff;
              end
            endcase
          end
        end
        ST_ABORT: begin
          m_cmd   <= C_STOP;
          m_dat   <= 8'd0;
          abort_q <= 1'b1;
        end
        default: ;
      endcase
      if (state_nxt == ST_CLR && state != ST_CLR) begin
        m_cmd <= C_CLRS;
        m_dat <= 8'd0;
      end
      // response fields only change as a new response is presented
      if (state_nxt == ST_RESP && state != ST_RESP) begin
        rsp_err <= err_nxt;
        if (rnw_q && err_nxt == E_OK) rsp_rdata <= rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed bench with a small behavioural i2c_master stand-in.
module tb_i2c_reg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_addr;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid;
  logic [2:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic [4:0] m_cmd;
  logic       m_ws;
  logic [7:0] m_dat;
  logic [6:0] m_stat;
  logic [7:0] m_dat_in;

  localparam logic [6:0] B_DON = 7'h01, B_ERR = 7'h02, B_ALO = 7'h04,
                         B_BBL = 7'h08, B_ACK = 7'h10, B_BSY = 7'h20;

  always #5 clk = ~clk;

  i2c_reg_seq #(.TMO_CYC(50)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .m_cmd(m_cmd), .m_ws(m_ws), .m_dat(m_dat),
    .m_stat(m_stat), .m_dat_in(m_dat_in)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // master model state and per-transaction knobs
  logic [6:0]  stat;
  logic [7:0]  rd_byte;
  logic [15:0] log_q [0:255];
  int          log_n = 0;
  int          cyc = 0, ws_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  int          nack_at, err_at, busy;
  logic [6:0]  err_bits;
  bit          hang, go;

  assign m_stat   = stat;
  assign m_dat_in = rd_byte;

  // master stand-in: status goes busy the cycle after ws, done 3 cycles later
  always @(negedge clk) begin
    cyc++;
    if (rsp_valid) begin
      rsp_cyc = cyc;
      rsp_cnt++;
    end
    if (rst) begin
      stat = 7'h00;
      go   = 1'b0;
      busy = 0;
    end else begin
      if (busy > 0 && !hang) begin
        busy--;
        if (busy == 0)
          stat = B_DON | ((log_n - 1 == nack_at) ? 7'h00 : B_ACK)
                       | ((log_n - 1 == err_at) ? err_bits : 7'h00);
      end
      if (go) begin
        go   = 1'b0;
        stat = B_BSY;
        busy = 3;
      end
      if (m_ws) begin
        if (log_n < 256) log_q[log_n] = {3'b000, m_cmd, m_dat};
        log_n++;
        ws_cyc = cyc;
        if (m_cmd == 5'h00) stat = 7'h00;
        else                go   = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
    chk(tag, (idx < 256) ? {16'h0, log_q[idx]} : 32'hdead, {16'h0, exp});
  endtask

  task automatic xact(input string tag, input bit rnw, input logic [6:0] a,
                      input logic [7:0] r, input logic [7:0] w,
                      input int nk, input int ek, input logic [6:0] eb,
                      input logic [2:0] exp_err, output int base);
    int i;
    base     = log_n;
    nack_at  = (nk < 0) ? -1 : base + nk;
    err_at   = (ek < 0) ? -1 : base + ek;
    err_bits = eb;
    req_rnw = rnw; req_addr = a; req_reg = r; req_wdata = w;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, ".busy_ready"}, req_ready, 0);
    i = 0;
    while (!rsp_valid && i < 400) begin
      tick();
      i++;
    end
    chk({tag, ".rsp_seen"}, rsp_valid, 1);
    chk({tag, ".err"}, rsp_err, exp_err);
    tick();
    chk({tag, ".pulse"}, rsp_valid, 0);
    chk({tag, ".ready_again"}, req_ready, 1);
  endtask

  initial begin
    int b, r0, i;
    rst = 1'b1;
    req_valid = 1'b0; req_rnw = 1'b0; req_addr = 7'h0; req_reg = 8'h0; req_wdata = 8'h0;
    nack_at = -1; err_at = -1; err_bits = 7'h0; hang = 1'b0; rd_byte = 8'h00;
    repeat (3) tick();
    chk("rst.ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.err", rsp_err, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.ws", m_ws, 0);
    chk("rst.cmd", m_cmd, 0);
    chk("rst.dat", m_dat, 0);
    rst = 1'b0;
    tick();

    // plain register write: S A0 10 A5 P, then status clear
    xact("wr", 0, 7'h50, 8'h10, 8'hA5, -1, -1, 7'h0, 3'd0, b);
    chk("wr.ncmd", log_n - b, 4);
    chk_log("wr.c0", b + 0, 16'h09A0);
    chk_log("wr.c1", b + 1, 16'h0810);
    chk_log("wr.c2", b + 2, 16'h0AA5);
    chk_log("wr.c3", b + 3, 16'h0000);

    // register read with restart
    rd_byte = 8'h3C;
    xact("rd", 1, 7'h50, 8'h22, 8'h00, -1, -1, 7'h0, 3'd0, b);
    chk("rd.rdata", rsp_rdata, 8'h3C);
    chk("rd.ncmd", log_n - b, 5);
    chk_log("rd.c0", b + 0, 16'h09A0);
    chk_log("rd.c1", b + 1, 16'h0822);
    chk_log("rd.c2", b + 2, 16'h09A1);
    chk_log("rd.c3", b + 3, 16'h16FF);
    chk_log("rd.c4", b + 4, 16'h0000);

    // address NACK: STOP then clear; read data from before is kept
    xact("anak", 0, 7'h51, 8'h10, 8'h11, 0, -1, 7'h0, 3'd1, b);
    chk("anak.ncmd", log_n - b, 3);
    chk_log("anak.c0", b + 0, 16'h09A2);
    chk_log("anak.stop", b + 1, 16'h0200);
    chk_log("anak.clr", b + 2, 16'h0000);
    chk("anak.rdata_hold", rsp_rdata, 8'h3C);

    // register byte NACK
    xact("rnak", 0, 7'h50, 8'h33, 8'h44, 1, -1, 7'h0, 3'd2, b);
    chk("rnak.ncmd", log_n - b, 4);
    chk_log("rnak.stop", b + 2, 16'h0200);

    // write data byte NACK
    xact("dnak", 0, 7'h50, 8'h33, 8'h44, 2, -1, 7'h0, 3'd2, b);
    chk_log("dnak.stop", b + 3, 16'h0200);

    // NACK on the restart address of a read counts as address NACK
    xact("srnak", 1, 7'h50, 8'h22, 8'h00, 2, -1, 7'h0, 3'd1, b);
    chk("srnak.ncmd", log_n - b, 5);
    chk_log("srnak.stop", b + 3, 16'h0200);

    // arbitration lost on data byte: no STOP, straight to clear
    xact("alo", 0, 7'h50, 8'h10, 8'hA5, -1, 2, B_ERR | B_ALO, 3'd3, b);
    chk("alo.ncmd", log_n - b, 4);
    chk_log("alo.clr", b + 3, 16'h0000);

    // bus busy at start
    xact("bbl", 0, 7'h50, 8'h10, 8'hA5, -1, 0, B_ERR | B_BBL, 3'd4, b);
    chk("bbl.ncmd", log_n - b, 2);

    // ALO wins over BBL
    xact("prec", 0, 7'h50, 8'h10, 8'hA5, -1, 1, B_ERR | B_ALO | B_BBL, 3'd3, b);

    // ERR flag wins over missing ACK
    xact("errnak", 0, 7'h50, 8'h10, 8'hA5, 0, 0, B_ERR, 3'd5, b);
    chk("errnak.ncmd", log_n - b, 2);

    // missing ACK on the read byte is not an error
    rd_byte = 8'h5A;
    xact("p3nak", 1, 7'h50, 8'h22, 8'h00, 3, -1, 7'h0, 3'd0, b);
    chk("p3nak.rdata", rsp_rdata, 8'h5A);

    // protocol error on read byte: read data register holds
    rd_byte = 8'hEE;
    xact("p3err", 1, 7'h50, 8'h22, 8'h00, -1, 3, B_ERR, 3'd5, b);
    chk("p3err.rdata_hold", rsp_rdata, 8'h5A);

    // reset during P1 of a write: outputs clear, no response
    b = log_n; nack_at = -1; err_at = -1;
    r0 = rsp_cnt;
    req_rnw = 0; req_addr = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    i = 0;
    while (log_n < b + 2 && i < 100) begin
      tick();
      i++;
    end
    chk("mid.p1_reached", log_n - b, 2);
    rst = 1'b1;
    tick();
    chk("mid.ready", req_ready, 1);
    chk("mid.ws", m_ws, 0);
    chk("mid.cmd", m_cmd, 0);
    chk("mid.dat", m_dat, 0);
    chk("mid.err", rsp_err, 0);
    chk("mid.rdata", rsp_rdata, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("mid.no_rsp", rsp_cnt - r0, 0);

    // timeout: master never finishes
    hang = 1'b1;
    xact("tmo", 0, 7'h50, 8'h10, 8'hA5, -1, -1, 7'h0, 3'd6, b);
    chk("tmo.ncmd", log_n - b, 1);
    chk("tmo.latency", rsp_cyc - ws_cyc, 53);

    // master still busy: next request must not strobe ws
    b = log_n;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    chk("hold.no_ws", log_n - b, 0);
    chk("hold.ready", req_ready, 0);
    rst = 1'b1; hang = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
